// File: rtl/range_tracker.sv
// Per-channel windowed min/max/span (plus sum when RANGE_TRACKER_SUM_EN is defined) over WIN accepted samples.
// Report appears the cycle after the WIN-th accept and holds until out_ready; in_ready is low while reporting or during clr.
module range_tracker #(
  parameter int W   = 4,
  parameter int CH  = 2,
  parameter int WIN = 8,
  parameter int CW  = $clog2(WIN + 1),
  parameter int SW  = W + $clog2(WIN) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CH*W-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CH*W-1:0] out_min,
  output logic [CH*W-1:0] out_max,
  output logic [CH*W-1:0] out_span,
  output logic [CH*SW-1:0] out_sum
);

  typedef enum logic {ACC = 1'b0, RPT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          accept, first, last;

  assign in_ready  = (state == ACC) && !clr;
  assign out_valid = (state == RPT);
  assign accept    = in_valid && in_ready;
  assign first     = (cnt == '0);
  assign last      = (cnt == CW'(WIN - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACC;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ACC;
    end else begin
      case (state)
        ACC:     if (accept && last) state_nxt = RPT;
        RPT:     if (out_ready)      state_nxt = ACC;
        default: state_nxt = ACC;
      endcase
    end
  end

  // cnt parks at WIN during the report and clears on the report handshake
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        cnt <= '0;
    else if (clr)                    cnt <= '0;
    else if (accept)                 cnt <= cnt + CW'(1);
    else if (out_valid && out_ready) cnt <= '0;
  end

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [W-1:0] smp, mn, mx;

    assign smp = in_data[k*W +: W];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mn <= '1;
        mx <= '0;
      end else if (clr) begin
        mn <= '1;
        mx <= '0;
      end else if (accept) begin
        if (first || smp < mn) mn <= smp;
        if (first || smp > mx) mx <= smp;
      end
    end

    assign out_min[k*W +: W]  = mn;
    assign out_max[k*W +: W]  = mx;
    assign out_span[k*W +: W] = out_valid ? (mx - mn) : '0;

`ifdef RANGE_TRACKER_SUM_EN
    logic [SW-1:0] sm;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)        sm <= '0;
      else if (clr)    sm <= '0;
      else if (accept) sm <= first ? SW'(smp) : sm + SW'(smp);
    end

    assign out_sum[k*SW +: SW] = sm;
`else
    assign out_sum[k*SW +: SW] = '0;
`endif
  end

endmodule

// File: tb/tb_range_tracker.sv
// Scoreboarded bench for range_tracker: a WIN=4 instance for the main scenarios and a WIN=1 instance.
module tb_range_tracker;

  typedef struct {
    logic [7:0]  mn;
    logic [7:0]  mx;
    logic [7:0]  sp;
    logic [13:0] sm;
  } exp_t;

  logic        clk = 0;
  logic        rst = 0;
  logic        clr = 0;
  logic        in_valid = 0, in_valid1 = 0;
  logic        in_ready, in_ready1;
  logic [7:0]  in_data = '0, in_data1 = '0;
  logic        out_valid, out_valid1;
  logic        out_ready = 1, out_ready1 = 1;
  logic [7:0]  out_min, out_max, out_span;
  logic [7:0]  out_min1, out_max1, out_span1;
  logic [13:0] out_sum;
  logic [9:0]  out_sum1;

  int   checks = 0, failures = 0;
  int   rpt4 = 0, rpt1 = 0;
  exp_t q4[$], q1[$];

  always #5 clk = ~clk;

  range_tracker #(.W(4), .CH(2), .WIN(4)) dut4 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_min(out_min), .out_max(out_max), .out_span(out_span), .out_sum(out_sum)
  );

  range_tracker #(.W(4), .CH(2), .WIN(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_min(out_min1), .out_max(out_max1), .out_span(out_span1), .out_sum(out_sum1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected packed sums for each build
  function automatic logic [13:0] s4(input int a1, input int a0);
`ifdef RANGE_TRACKER_SUM_EN
    return {7'(a1), 7'(a0)};
`else
    return 14'd0;
`endif
  endfunction

  function automatic logic [13:0] s1(input int a1, input int a0);
`ifdef RANGE_TRACKER_SUM_EN
    return {4'd0, 5'(a1), 5'(a0)};
`else
    return 14'd0;
`endif
  endfunction

  function automatic exp_t mk(input logic [7:0] mn, input logic [7:0] mx,
                              input logic [7:0] sp, input logic [13:0] sm);
    exp_t e;
    e.mn = mn; e.mx = mx; e.sp = sp; e.sm = sm;
    return e;
  endfunction

  // Monitors: a report is consumed on a posedge where out_valid & out_ready
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      exp_t e;
      rpt4++;
      check("dut4_report_expected", (q4.size() > 0), 1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        check("dut4_min", out_min, e.mn);
        check("dut4_max", out_max, e.mx);
        check("dut4_span", out_span, e.sp);
        check("dut4_sum", out_sum, e.sm);
      end
    end
  end

  always @(negedge clk) begin
    if (rst && out_valid1 && out_ready1) begin
      exp_t e;
      rpt1++;
      check("dut1_report_expected", (q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("dut1_min", out_min1, e.mn);
        check("dut1_max", out_max1, e.mx);
        check("dut1_span", out_span1, e.sp);
        check("dut1_sum", {4'd0, out_sum1}, e.sm);
      end
    end
  end

  // Present one sample and hold it until accepted; returns at posedge+1
  task automatic send(input logic [7:0] d);
    int n = 0;
    in_valid = 1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #23 rst = 1;

    // Post-reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_min", out_min, 8'hFF);
    check("rst_max", out_max, 8'h00);
    check("rst_span", out_span, 8'h00);
    check("rst_sum", out_sum, 14'd0);
    @(posedge clk); #1;

    // Scenario 1: basic window, single-cycle report
    q4.push_back(mk(8'hF1, 8'hF9, 8'h08, s4(60, 20)));
    send(8'hF3); send(8'hF9); send(8'hF1); send(8'hF7);
    @(negedge clk);
    check("s1_valid_rise", out_valid, 1);
    check("s1_in_ready_low", in_ready, 0);
    @(negedge clk);
    check("s1_valid_one_cycle", out_valid, 0);
    @(posedge clk); #1;

    // Scenario 2: report held under backpressure, input ignored
    out_ready = 0;
    q4.push_back(mk(8'hF1, 8'hF9, 8'h08, s4(60, 20)));
    send(8'hF3); send(8'hF9); send(8'hF1); send(8'hF7);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = 8'h00;
      @(negedge clk);
      check("s2_hold_valid", out_valid, 1);
      check("s2_hold_in_ready", in_ready, 0);
      check("s2_hold_min", out_min, 8'hF1);
      check("s2_hold_span", out_span, 8'h08);
      @(posedge clk); #1;
    end
    in_valid  = 0;
    out_ready = 1;
    @(negedge clk);
    @(posedge clk); #1;

    // Scenario 3: clr after two samples; coincident sample dropped
    send(8'h02); send(8'h04);
    clr = 1; in_valid = 1; in_data = 8'h00;
    @(negedge clk);
    check("s3_clr_in_ready", in_ready, 0);
    @(posedge clk); #1;
    clr = 0; in_valid = 0;
    q4.push_back(mk(8'h35, 8'hC8, 8'h93, s4(30, 26)));
    send(8'hC5); send(8'h36); send(8'h97); send(8'h68);
    @(negedge clk);
    @(posedge clk); #1;

    // Scenario 4: async reset while a report is pending
    out_ready = 0;
    send(8'h11); send(8'h11); send(8'h11); send(8'h11);
    @(negedge clk);
    check("s4_pre_valid", out_valid, 1);
    #2 rst = 0;
    #1;
    check("s4_async_valid", out_valid, 0);
    check("s4_async_in_ready", in_ready, 1);
    check("s4_async_min", out_min, 8'hFF);
    @(posedge clk); #1;
    rst = 1;
    out_ready = 1;
    q4.push_back(mk(8'h04, 8'h34, 8'h30, s4(6, 16)));
    send(8'h04); send(8'h14); send(8'h24); send(8'h34);
    @(negedge clk);
    @(posedge clk); #1;

    // Scenario 5: continuous traffic, one report every 5th cycle
    q4.push_back(mk(8'h50, 8'h53, 8'h03, s4(20, 6)));
    q4.push_back(mk(8'h55, 8'h58, 8'h03, s4(20, 26)));
    in_valid = 1;
    for (int i = 0; i < 10; i++) begin
      in_data = {4'd5, 4'(i)};
      @(negedge clk);
      check("s5_in_ready", in_ready, (i % 5 != 4));
      check("s5_out_valid", out_valid, (i % 5 == 4));
      @(posedge clk); #1;
    end
    in_valid = 0;
    @(negedge clk);
    check("s5_idle_valid", out_valid, 0);
    @(posedge clk); #1;

    // Scenario 6: WIN=1 reports every accepted sample
    for (int i = 0; i < 3; i++) begin
      logic [3:0] s;
      s = (i == 0) ? 4'd0 : (i == 1) ? 4'd15 : 4'd8;
      q1.push_back(mk({s, s}, {s, s}, 8'h00, s1(s, s)));
      in_valid1 = 1;
      in_data1  = {s, s};
      @(negedge clk);
      check("s6_in_ready", in_ready1, 1);
      @(posedge clk); #1;
      in_valid1 = 0;
      @(negedge clk);
      check("s6_out_valid", out_valid1, 1);
      @(posedge clk); #1;
    end

    repeat (2) @(posedge clk);
    #1;
    check("rpt4_count", rpt4, 6);
    check("rpt1_count", rpt1, 3);
    check("q4_drained", q4.size(), 0);
    check("q1_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
